// File: rtl/hazard_controller_if.sv
// Pipeline-side view of the hazard controller: register ids and write flags in, stall/flush/forward controls out.
// Combinational path only; no handshake, the pipeline obeys stall_* every cycle.
interface hazard_controller_if;
    logic [4:0] Rs_decode;
    logic [4:0] Rt_decode;
    logic [4:0] Rs_execute;
    logic [4:0] Rt_execute;
    logic [4:0] write_register_execute;
    logic [4:0] write_register_memory;
    logic [4:0] write_register_writeback;
    logic       register_write_execute;
    logic       register_write_memory;
    logic       register_write_writeback;
    logic       memory_to_register_execute;
    logic       memory_to_register_memory;
    logic       branch_decode;
    logic       hi_lo_read_decode;
    logic       muldiv_decode;
    logic       muldiv_start_execute;
    logic       muldiv_is_div_execute;
    logic       stall_fetch;
    logic       stall_decode;
    logic       flush_execute;
    logic [1:0] forward_A_execute;
    logic [1:0] forward_B_execute;
    logic       forward_A_decode;
    logic       forward_B_decode;
    logic       muldiv_busy;
    logic       hi_lo_write_enable;

    modport master (
        output Rs_decode, Rt_decode, Rs_execute, Rt_execute,
        output write_register_execute, write_register_memory, write_register_writeback,
        output register_write_execute, register_write_memory, register_write_writeback,
        output memory_to_register_execute, memory_to_register_memory,
        output branch_decode, hi_lo_read_decode, muldiv_decode,
        output muldiv_start_execute, muldiv_is_div_execute,
        input  stall_fetch, stall_decode, flush_execute,
        input  forward_A_execute, forward_B_execute, forward_A_decode, forward_B_decode,
        input  muldiv_busy, hi_lo_write_enable
    );

    modport slave (
        input  Rs_decode, Rt_decode, Rs_execute, Rt_execute,
        input  write_register_execute, write_register_memory, write_register_writeback,
        input  register_write_execute, register_write_memory, register_write_writeback,
        input  memory_to_register_execute, memory_to_register_memory,
        input  branch_decode, hi_lo_read_decode, muldiv_decode,
        input  muldiv_start_execute, muldiv_is_div_execute,
        output stall_fetch, stall_decode, flush_execute,
        output forward_A_execute, forward_B_execute, forward_A_decode, forward_B_decode,
        output muldiv_busy, hi_lo_write_enable
    );
endinterface

// File: rtl/hazard_controller.sv
// Hazard/forwarding unit for the 5-stage MIPS pipeline plus HI/LO mul/div occupancy sequencer.
// Forwarding and stalls are combinational; the sequencer writes HI/LO LATENCY cycles after issue.
module hazard_controller #(
    parameter int MULT_LATENCY = 4,
    parameter int DIV_LATENCY  = 32,
    parameter int COUNT_WIDTH  = 6
) (
    input  logic                clk,
    input  logic                clear,
    hazard_controller_if.slave  hz
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [COUNT_WIDTH-1:0] MULT_LOAD = COUNT_WIDTH'(MULT_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] DIV_LOAD  = COUNT_WIDTH'(DIV_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = COUNT_WIDTH'(1);

    state_t                 state, state_next;
    logic [COUNT_WIDTH-1:0] count, count_next;
    logic                   write_pulse;

    logic [1:0] fwd_a_ex, fwd_b_ex;
    logic       ex_writes, mem_writes, wb_writes, mem_loads, ex_loads;
    logic       load_use_stall, branch_stall, muldiv_stall, stall;

    // $0 is hardwired to zero, so a write to it never creates a dependency.
    assign ex_writes  = hz.register_write_execute     && (hz.write_register_execute   != 5'd0);
    assign mem_writes = hz.register_write_memory      && (hz.write_register_memory    != 5'd0);
    assign wb_writes  = hz.register_write_writeback   && (hz.write_register_writeback != 5'd0);
    assign ex_loads   = hz.memory_to_register_execute && (hz.write_register_execute   != 5'd0);
    assign mem_loads  = hz.memory_to_register_memory  && (hz.write_register_memory    != 5'd0);

    always_comb begin
        fwd_a_ex = 2'b00;
        if (mem_writes && (hz.write_register_memory == hz.Rs_execute))
            fwd_a_ex = 2'b10;
        else if (wb_writes && (hz.write_register_writeback == hz.Rs_execute))
            fwd_a_ex = 2'b01;
    end

    always_comb begin
        fwd_b_ex = 2'b00;
        if (mem_writes && (hz.write_register_memory == hz.Rt_execute))
            fwd_b_ex = 2'b10;
        else if (wb_writes && (hz.write_register_writeback == hz.Rt_execute))
            fwd_b_ex = 2'b01;
    end

    assign hz.forward_A_execute = fwd_a_ex;
    assign hz.forward_B_execute = fwd_b_ex;
    assign hz.forward_A_decode  = mem_writes && (hz.write_register_memory == hz.Rs_decode);
    assign hz.forward_B_decode  = mem_writes && (hz.write_register_memory == hz.Rt_decode);

    assign load_use_stall = ex_loads &&
        ((hz.write_register_execute == hz.Rs_decode) || (hz.write_register_execute == hz.Rt_decode));

    // The branch comparator sits in decode, so an ALU result still in execute or a load
    // still in memory cannot be forwarded in time.
    assign branch_stall = hz.branch_decode && (
        (ex_writes && ((hz.write_register_execute == hz.Rs_decode) ||
                       (hz.write_register_execute == hz.Rt_decode))) ||
        (mem_loads && ((hz.write_register_memory == hz.Rs_decode) ||
                       (hz.write_register_memory == hz.Rt_decode))));

    assign muldiv_stall = !clear && (hz.hi_lo_read_decode || hz.muldiv_decode) &&
                          ((state == BUSY) || hz.muldiv_start_execute);

    assign stall            = load_use_stall || branch_stall || muldiv_stall;
    assign hz.stall_fetch   = stall;
    assign hz.stall_decode  = stall;
    assign hz.flush_execute = stall;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A start seen while BUSY is dropped: decode already holds any second mul/div back.
    always_comb begin
        state_next  = state;
        count_next  = count;
        write_pulse = 1'b0;
        case (state)
            IDLE: begin
                if (hz.muldiv_start_execute) begin
                    count_next = hz.muldiv_is_div_execute ? DIV_LOAD : MULT_LOAD;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (count == '0) begin
                    write_pulse = 1'b1;
                    state_next  = IDLE;
                end else begin
                    count_next = count - COUNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign hz.muldiv_busy        = (state == BUSY);
    assign hz.hi_lo_write_enable = write_pulse;

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller: inline combinational checks plus a HI/LO write-pulse scoreboard.
module tb_hazard_controller;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic clk = 1'b0;
    logic clear;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   exp_pulse[$];

    hazard_controller_if hz();

    hazard_controller #(
        .MULT_LATENCY(MULT_LAT),
        .DIV_LATENCY (DIV_LAT),
        .COUNT_WIDTH (6)
    ) dut (
        .clk  (clk),
        .clear(clear),
        .hz   (hz)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every observed write pulse must match the oldest expected pulse cycle.
    always @(negedge clk) begin : pulse_monitor
        int e;
        if (hz.hi_lo_write_enable === 1'b1) begin
            checks++;
            if (exp_pulse.size() == 0) begin
                errors++;
                $display("FAIL hi_lo_pulse: pulse at cycle %0d, none expected", cyc);
            end else begin
                e = exp_pulse.pop_front();
                if (cyc !== e) begin
                    errors++;
                    $display("FAIL hi_lo_pulse: pulse at cycle %0d, expected cycle %0d", cyc, e);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        hz.Rs_decode = 5'd0;  hz.Rt_decode = 5'd0;
        hz.Rs_execute = 5'd0; hz.Rt_execute = 5'd0;
        hz.write_register_execute = 5'd0;
        hz.write_register_memory = 5'd0;
        hz.write_register_writeback = 5'd0;
        hz.register_write_execute = 1'b0;
        hz.register_write_memory = 1'b0;
        hz.register_write_writeback = 1'b0;
        hz.memory_to_register_execute = 1'b0;
        hz.memory_to_register_memory = 1'b0;
        hz.branch_decode = 1'b0;
        hz.hi_lo_read_decode = 1'b0;
        hz.muldiv_decode = 1'b0;
        hz.muldiv_start_execute = 1'b0;
        hz.muldiv_is_div_execute = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        idle_inputs();
        hz.muldiv_start_execute = 1'b1;
        hz.hi_lo_read_decode = 1'b1;
        hz.register_write_memory = 1'b1;
        hz.write_register_memory = 5'd5;
        hz.Rs_execute = 5'd5;
        @(negedge clk);
        checks++;
        if (hz.muldiv_busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", hz.muldiv_busy);
        end
        checks++;
        if (hz.hi_lo_write_enable !== 1'b0) begin
            errors++; $display("FAIL reset_hilo_we: got %b want 0", hz.hi_lo_write_enable);
        end
        checks++;
        if (hz.stall_fetch !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b want 0", hz.stall_fetch);
        end
        checks++;
        if (hz.forward_A_execute !== 2'b10) begin
            errors++; $display("FAIL reset_fwd_a: got %b want 10", hz.forward_A_execute);
        end
        step();
        clear = 1'b0;
        idle_inputs();
    endtask

    task automatic test_load_use();
        step();
        idle_inputs();
        hz.memory_to_register_execute = 1'b1;
        hz.register_write_execute = 1'b1;
        hz.write_register_execute = 5'd8;
        hz.Rs_decode = 5'd8;
        hz.Rt_decode = 5'd9;
        @(negedge clk);
        checks++;
        if ({hz.stall_fetch, hz.stall_decode, hz.flush_execute} !== 3'b111) begin
            errors++; $display("FAIL load_use_stall: got %b want 111",
                               {hz.stall_fetch, hz.stall_decode, hz.flush_execute});
        end
        // Bubble now in execute, load moved to memory.
        step();
        idle_inputs();
        hz.register_write_memory = 1'b1;
        hz.memory_to_register_memory = 1'b1;
        hz.write_register_memory = 5'd8;
        hz.Rs_decode = 5'd8;
        hz.Rt_decode = 5'd9;
        @(negedge clk);
        checks++;
        if ({hz.stall_fetch, hz.stall_decode, hz.flush_execute} !== 3'b000) begin
            errors++; $display("FAIL load_use_release: got %b want 000",
                               {hz.stall_fetch, hz.stall_decode, hz.flush_execute});
        end
        step();
        idle_inputs();
        hz.memory_to_register_execute = 1'b1;
        hz.register_write_execute = 1'b1;
        hz.write_register_execute = 5'd0;
        @(negedge clk);
        checks++;
        if (hz.stall_fetch !== 1'b0) begin
            errors++; $display("FAIL load_use_r0: got %b want 0", hz.stall_fetch);
        end
        step();
        hz.write_register_execute = 5'd9;
        hz.Rs_decode = 5'd1;
        hz.Rt_decode = 5'd9;
        @(negedge clk);
        checks++;
        if (hz.stall_decode !== 1'b1) begin
            errors++; $display("FAIL load_use_rt: got %b want 1", hz.stall_decode);
        end
    endtask

    task automatic test_forwarding();
        step();
        idle_inputs();
        hz.register_write_memory = 1'b1;
        hz.write_register_memory = 5'd5;
        hz.register_write_writeback = 1'b1;
        hz.write_register_writeback = 5'd5;
        hz.Rs_execute = 5'd5;
        hz.Rt_execute = 5'd6;
        @(negedge clk);
        checks++;
        if (hz.forward_A_execute !== 2'b10) begin
            errors++; $display("FAIL fwd_a_mem_priority: got %b want 10", hz.forward_A_execute);
        end
        checks++;
        if (hz.forward_B_execute !== 2'b00) begin
            errors++; $display("FAIL fwd_b_none: got %b want 00", hz.forward_B_execute);
        end
        step();
        hz.register_write_memory = 1'b0;
        @(negedge clk);
        checks++;
        if (hz.forward_A_execute !== 2'b01) begin
            errors++; $display("FAIL fwd_a_wb: got %b want 01", hz.forward_A_execute);
        end
        step();
        hz.register_write_memory = 1'b1;
        hz.Rt_execute = 5'd5;
        hz.Rs_execute = 5'd7;
        @(negedge clk);
        checks++;
        if ({hz.forward_A_execute, hz.forward_B_execute} !== 4'b0010) begin
            errors++; $display("FAIL fwd_b_mem: got %b want 0010",
                               {hz.forward_A_execute, hz.forward_B_execute});
        end
        step();
        hz.write_register_memory = 5'd0;
        hz.write_register_writeback = 5'd0;
        hz.Rs_execute = 5'd0;
        hz.Rt_execute = 5'd0;
        @(negedge clk);
        checks++;
        if ({hz.forward_A_execute, hz.forward_B_execute} !== 4'b0000) begin
            errors++; $display("FAIL fwd_r0: got %b want 0000",
                               {hz.forward_A_execute, hz.forward_B_execute});
        end
    endtask

    task automatic test_branch();
        step();
        idle_inputs();
        hz.branch_decode = 1'b1;
        hz.Rs_decode = 5'd3;
        hz.Rt_decode = 5'd4;
        hz.register_write_execute = 1'b1;
        hz.write_register_execute = 5'd3;
        @(negedge clk);
        checks++;
        if ({hz.stall_fetch, hz.forward_A_decode} !== 2'b10) begin
            errors++; $display("FAIL branch_ex_stall: got %b want 10",
                               {hz.stall_fetch, hz.forward_A_decode});
        end
        step();
        idle_inputs();
        hz.branch_decode = 1'b1;
        hz.Rs_decode = 5'd3;
        hz.Rt_decode = 5'd4;
        hz.register_write_memory = 1'b1;
        hz.write_register_memory = 5'd3;
        @(negedge clk);
        checks++;
        if ({hz.stall_fetch, hz.forward_A_decode, hz.forward_B_decode} !== 3'b010) begin
            errors++; $display("FAIL branch_mem_fwd: got %b want 010",
                               {hz.stall_fetch, hz.forward_A_decode, hz.forward_B_decode});
        end
        step();
        hz.memory_to_register_memory = 1'b1;
        hz.write_register_memory = 5'd4;
        @(negedge clk);
        checks++;
        if ({hz.flush_execute, hz.forward_B_decode} !== 2'b11) begin
            errors++; $display("FAIL branch_mem_load: got %b want 11",
                               {hz.flush_execute, hz.forward_B_decode});
        end
    endtask

    task automatic test_mult();
        int c;
        step();
        idle_inputs();
        hz.muldiv_start_execute = 1'b1;
        hz.muldiv_is_div_execute = 1'b0;
        hz.hi_lo_read_decode = 1'b1;
        c = cyc;
        exp_pulse.push_back(c + MULT_LAT);
        @(negedge clk);
        checks++;
        if ({hz.stall_fetch, hz.muldiv_busy} !== 2'b10) begin
            errors++; $display("FAIL mult_issue: got %b want 10", {hz.stall_fetch, hz.muldiv_busy});
        end
        for (int k = 1; k <= MULT_LAT + 1; k++) begin
            step();
            hz.muldiv_start_execute = 1'b0;
            @(negedge clk);
            checks++;
            if ({hz.stall_fetch, hz.muldiv_busy, hz.hi_lo_write_enable} !==
                {(k <= MULT_LAT), (k <= MULT_LAT), (k == MULT_LAT)}) begin
                errors++;
                $display("FAIL mult_seq k=%0d: got %b want %b", k,
                         {hz.stall_fetch, hz.muldiv_busy, hz.hi_lo_write_enable},
                         {(k <= MULT_LAT), (k <= MULT_LAT), (k == MULT_LAT)});
            end
        end
        idle_inputs();
    endtask

    task automatic test_clear_abort();
        step();
        idle_inputs();
        hz.muldiv_start_execute = 1'b1;
        hz.muldiv_is_div_execute = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            hz.muldiv_start_execute = 1'b0;
            hz.hi_lo_read_decode = 1'b1;
        end
        @(negedge clk);
        checks++;
        if ({hz.muldiv_busy, hz.stall_fetch} !== 2'b11) begin
            errors++; $display("FAIL div_busy_before_clear: got %b want 11",
                               {hz.muldiv_busy, hz.stall_fetch});
        end
        step();
        clear = 1'b1;
        #1;
        checks++;
        if ({hz.muldiv_busy, hz.stall_fetch} !== 2'b00) begin
            errors++; $display("FAIL clear_immediate: got %b want 00",
                               {hz.muldiv_busy, hz.stall_fetch});
        end
        step();
        clear = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            checks++;
            if ({hz.muldiv_busy, hz.stall_fetch, hz.hi_lo_write_enable} !== 3'b000) begin
                errors++; $display("FAIL clear_abort k=%0d: got %b want 000", k,
                                   {hz.muldiv_busy, hz.stall_fetch, hz.hi_lo_write_enable});
            end
            step();
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        int c;
        int rel;
        bit released;
        step();
        idle_inputs();
        hz.muldiv_start_execute = 1'b1;
        hz.muldiv_is_div_execute = 1'b1;
        hz.muldiv_decode = 1'b1;
        c = cyc;
        exp_pulse.push_back(c + DIV_LAT);
        // Mult leaves decode the cycle after the unit goes idle, then issues one cycle later.
        exp_pulse.push_back(c + DIV_LAT + 2 + MULT_LAT);
        @(negedge clk);
        checks++;
        if (hz.stall_decode !== 1'b1) begin
            errors++; $display("FAIL b2b_issue_stall: got %b want 1", hz.stall_decode);
        end
        released = 1'b0;
        rel = 0;
        for (int k = 1; k <= DIV_LAT + 5; k++) begin
            if (!released) begin
                step();
                hz.muldiv_start_execute = 1'b0;
                @(negedge clk);
                if (hz.stall_decode === 1'b0) begin
                    released = 1'b1;
                    rel = cyc;
                end
            end
        end
        checks++;
        if (!released || rel !== c + DIV_LAT + 1) begin
            errors++; $display("FAIL b2b_release: released=%0b at cycle %0d want cycle %0d",
                               released, rel, c + DIV_LAT + 1);
        end
        step();
        idle_inputs();
        hz.muldiv_start_execute = 1'b1;
        hz.muldiv_is_div_execute = 1'b0;
        step();
        idle_inputs();
        for (int k = 0; k < MULT_LAT + 3; k++) step();
        @(negedge clk);
        checks++;
        if (exp_pulse.size() !== 0) begin
            errors++; $display("FAIL b2b_pulses: %0d expected pulses missing", exp_pulse.size());
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_forwarding();
        test_branch();
        test_mult();
        test_clear_abort();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
